ft_result_serializer: RTL and testbench

- Consumer end of the FT two-stage datapath output.
- Captures the parallel stage-2 result vector Y (N elements × n bits, Q6.10) on a one-cycle valid pulse from the core.
- Buffers up to two vectors (ping/pong).
- Streams elements out one per cycle over a valid/ready interface, with element index and last-flag, to a narrow downstream sink (host or bus).

---
 rtl/ft_ser_pkg.sv | 16 +
 rtl/ft_result_serializer_elem_mux.sv | 18 +
 rtl/ft_result_serializer.sv | 124 ++++++++++++
 tb/tb_ft_result_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ft_ser_pkg.sv
// ft_ser_pkg: shared constants and types for the FT result serializer.
//   FT_N      elements per result vector (stage-2 neuron count)
//   FT_ELEM_W element width in bits (Q6.10)
//   FT_IDXW   element index width
//   FT_CNT_W  occupancy counter width (0..2 buffered vectors)
package ft_ser_pkg;

    localparam int FT_N      = 8;
    localparam int FT_ELEM_W = 16;
    localparam int FT_IDXW   = 3;
    localparam int FT_CNT_W  = 2;

    typedef logic [FT_ELEM_W-1:0]      elem_t;
    typedef logic [FT_N*FT_ELEM_W-1:0] vec_t;

endpackage

// File: rtl/ft_result_serializer_elem_mux.sv
// ft_elem_mux: combinational N:1 element selector.
// Ports:
//   vec  in  full result vector, element k at vec[k*FT_ELEM_W +: FT_ELEM_W]
//   idx  in  element index
//   elem out selected element
module ft_elem_mux
    import ft_ser_pkg::*;
(
    input  vec_t               vec,
    input  logic [FT_IDXW-1:0] idx,
    output elem_t              elem
);

    always_comb begin
        elem = vec[idx*FT_ELEM_W +: FT_ELEM_W];
    end

endmodule

// File: rtl/ft_result_serializer.sv
// ft_result_serializer: captures a parallel result vector on a one-cycle
// valid pulse, holds up to two vectors (ping/pong) and streams them out one
// element per cycle over valid/ready.
// Optional build macro: FT_SER_DROPCNT_EN adds a saturating drop counter.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   y_in, y_valid       parallel result vector and its one-cycle strobe
//   in_ready            a buffer slot is free
//   drop                registered pulse: a y_valid was discarded
//   out_data/out_idx    current element and its index
//   out_valid/out_ready stream handshake
//   out_last            current element is the last of its vector
//   busy                at least one vector buffered
//   drop_cnt            (FT_SER_DROPCNT_EN only) saturating discard count
module ft_result_serializer
    import ft_ser_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  vec_t               y_in,
    input  logic               y_valid,
    output logic               in_ready,
    output logic               drop,
    output elem_t              out_data,
    output logic [FT_IDXW-1:0] out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
`ifdef FT_SER_DROPCNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam logic [FT_IDXW-1:0]  LAST_IDX = FT_IDXW'(FT_N - 1);
    localparam logic [FT_CNT_W-1:0] FULL     = FT_CNT_W'(2);

    vec_t                slot0;
    vec_t                slot1;
    vec_t                rd_vec;
    logic [FT_CNT_W-1:0] count;
    logic [FT_CNT_W-1:0] count_next;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [FT_IDXW-1:0]  elem;
    logic                push;
    logic                drop_cond;
    logic                pop;
    logic                retire;

    // All decisions use the registered count, so a slot freed by a retire
    // this cycle cannot be reused by a push in the same cycle when full.
    assign push      = y_valid && (count != FULL);
    assign drop_cond = y_valid && (count == FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign retire    = pop && (elem == LAST_IDX);

    assign in_ready  = (count != FULL);
    assign busy      = (count != '0);
    assign out_idx   = elem;
    assign out_last  = out_valid && (elem == LAST_IDX);
    assign rd_vec    = rd_ptr ? slot1 : slot0;

    ft_elem_mux u_elem_mux (
        .vec  (rd_vec),
        .idx  (elem),
        .elem (out_data)
    );

    always_comb begin
        count_next = count;
        if (push && !retire) begin
            count_next = count + FT_CNT_W'(1);
        end else if (!push && retire) begin
            count_next = count - FT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            elem   <= '0;
            drop   <= 1'b0;
        end else begin
            count <= count_next;
            drop  <= drop_cond;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (retire) begin
                elem   <= '0;
                rd_ptr <= ~rd_ptr;
            end else if (pop) begin
                elem <= elem + FT_IDXW'(1);
            end
        end
    end

    // Slot storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            if (wr_ptr) begin
                slot1 <= y_in;
            end else begin
                slot0 <= y_in;
            end
        end
    end

`ifdef FT_SER_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_cond && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ft_result_serializer.sv
module tb_ft_result_serializer;
    import ft_ser_pkg::*;

    localparam int N = FT_N;
    localparam int W = FT_ELEM_W;

    logic               clk = 1'b0;
    logic               reset;
    vec_t               y_in;
    logic               y_valid;
    logic               in_ready;
    logic               drop;
    elem_t              out_data;
    logic [FT_IDXW-1:0] out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
`ifdef FT_SER_DROPCNT_EN
    logic [15:0]        drop_cnt;
    int                 m_dcnt;
`endif

    ft_result_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .y_in      (y_in),
        .y_valid   (y_valid),
        .in_ready  (in_ready),
        .drop      (drop),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
`ifdef FT_SER_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;

    // Reference model: FIFO of whole vectors plus the element position
    // within the head vector.
    vec_t mq[$];
    int   m_elem;
    bit   m_drop;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic vec_t pattern_vec();
        vec_t v;
        for (int k = 0; k < N; k++) v[k*W +: W] = 16'(16'h0101 * k);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < N; k++) v[k*W +: W] = 16'($urandom);
        return v;
    endfunction

    // Checks outputs of the current cycle, drives inputs, advances the model.
    task automatic step(input bit yv, input vec_t v, input bit rdy);
        bit   has;
        bit   push_m;
        bit   drop_m;
        vec_t head;
        has = (mq.size() != 0);
        check_val("out_valid", 32'(out_valid), 32'(has));
        check_val("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check_val("busy", 32'(busy), 32'(has));
        check_val("drop", 32'(drop), 32'(m_drop));
`ifdef FT_SER_DROPCNT_EN
        check_val("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
`endif
        if (has) begin
            head = mq[0];
            check_val("out_data", 32'(out_data), 32'(head[m_elem*W +: W]));
            check_val("out_idx", 32'(out_idx), 32'(m_elem));
            check_val("out_last", 32'(out_last), 32'(m_elem == N - 1));
        end else begin
            check_val("out_last_idle", 32'(out_last), 32'(0));
        end
        y_valid   = yv;
        y_in      = v;
        out_ready = rdy;
        push_m = yv && (mq.size() < 2);
        drop_m = yv && (mq.size() == 2);
        if (has && rdy) begin
            if (m_elem == N - 1) begin
                void'(mq.pop_front());
                m_elem = 0;
            end else begin
                m_elem++;
            end
        end
        if (push_m) mq.push_back(v);
        m_drop = drop_m;
`ifdef FT_SER_DROPCNT_EN
        if (drop_m && m_dcnt != 16'hFFFF) m_dcnt++;
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        y_valid   = 1'b1;
        y_in      = rand_vec();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        reset   = 1'b0;
        y_valid = 1'b0;
        mq.delete();
        m_elem = 0;
        m_drop = 0;
`ifdef FT_SER_DROPCNT_EN
        m_dcnt = 0;
`endif
    endtask

    initial begin
        vec_t a, b, c, d;
        reset     = 1'b1;
        y_valid   = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset then idle
        for (int i = 0; i < 10; i++) step(0, rand_vec(), 1'($urandom_range(0, 1)));

        // Single pattern vector with out_ready held high
        step(1, pattern_vec(), 1);
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // Backpressure with a random ready pattern
        step(1, rand_vec(), 0);
        for (int i = 0; i < 40; i++) step(0, '0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // Double buffer and drop: A, B buffered, C discarded
        a = rand_vec(); b = rand_vec(); c = rand_vec();
        step(1, a, 0);
        step(1, b, 0);
        step(1, c, 0);
        step(0, '0, 0);
        for (int i = 0; i < 18; i++) step(0, '0, 1);

        // Push coincident with retire of the last element
        step(1, rand_vec(), 1);
        for (int i = 0; i < 7; i++) step(0, '0, 1);
        step(1, rand_vec(), 1);
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // Reset mid-drain at element 3 of A with B buffered, then D
        a = rand_vec(); b = rand_vec(); d = rand_vec();
        step(1, a, 0);
        step(1, b, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        do_reset();
        step(1, d, 1);
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) == 0), rand_vec(), 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 20; i++) step(0, '0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
